// File: rtl/ultrasonic_phase_gen.sv
// ultrasonic_phase_gen
// Multi-channel phase-shifted square-wave generator for an ultrasonic
// transducer array. A shared counter runs over one carrier period; each
// channel derives its own phase by subtracting a per-channel delay, and
// drives high for the first half of that phase (or for `duty` clocks).
//
// Build option: define SHIFT_CTRL_DUTY_EN to add the `duty` port and a
// programmable high time. Without it, every channel runs at 50 % duty.
//
// Ports
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high reset
//   enable     run request level
//   update     one-cycle strobe: load period/shift(/duty) into shadows
//   period     carrier period in clocks (clamped up to MIN_PERIOD)
//   shift      per-channel delay, channel k at [k*CNT_W +: CNT_W]
//   burst_len  periods per burst, 0 = continuous
//   duty       high time in clocks (SHIFT_CTRL_DUTY_EN only)
//   ch_out     transducer drive outputs
//   sync       one-cycle pulse at the start of each period
//   busy       high whenever not idle
//   done       one-cycle pulse when a finite burst completes
//   shift_err  bit k set while shadow shift of channel k >= shadow period
module ultrasonic_phase_gen #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    update,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] shift,
    input  logic [CNT_W-1:0]        burst_len,
`ifdef SHIFT_CTRL_DUTY_EN
    input  logic [CNT_W-1:0]        duty,
`endif
    output logic [NUM_CH-1:0]       ch_out,
    output logic                    sync,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH-1:0]       shift_err
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t                    state, state_next;
    logic [CNT_W-1:0]          cnt, period_cnt;
    logic [CNT_W-1:0]          shadow_period, pend_period, period_in;
    logic [NUM_CH*CNT_W-1:0]   shadow_shift, pend_shift;
    logic                      pending, wrap, burst_last, finish;
    logic                      load_input, load_pend;
    logic [NUM_CH-1:0]         ch_next, err;
    logic [CNT_W:0]            cnt_x, per_x, thr_x, sh_x, phase;
`ifdef SHIFT_CTRL_DUTY_EN
    logic [CNT_W-1:0]          shadow_duty, pend_duty;
`endif

    // Clamp tiny periods so the counter always has room for a real waveform.
    assign period_in  = (period < MIN_P) ? MIN_P : period;
    assign wrap       = (cnt == shadow_period - ONE);
    assign burst_last = (burst_len != '0) && (period_cnt == burst_len - ONE);

    // In IDLE shadows follow the inputs directly on start or update; while
    // running, an update coincident with the wrap wins over a stale pending one.
    assign load_input = (state == IDLE) ? (enable | update) : (wrap & update);
    assign load_pend  = (state != IDLE) & wrap & pending & ~update;

    assign busy      = (state != IDLE);
    assign shift_err = err;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic. A finished burst takes priority over a stop request;
    // STOP only drains to the end of the current period.
    always_comb begin
        state_next = state;
        finish     = 1'b0;
        case (state)
            IDLE: if (enable) state_next = RUN;
            RUN: begin
                if (wrap && burst_last) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end else if (!enable) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (wrap && burst_last) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end else if (enable) begin
                    state_next = RUN;
                end else if (wrap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Carrier counter and completed-period count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            period_cnt <= '0;
        end else if (state == IDLE) begin
            if (enable) begin
                cnt        <= '0;
                period_cnt <= '0;
            end
        end else if (wrap) begin
            cnt        <= '0;
            period_cnt <= period_cnt + ONE;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    // Pending update capture: a later strobe overwrites an earlier one so
    // only the most recent values reach the shadows at the wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending     <= 1'b0;
            pend_period <= '0;
            pend_shift  <= '0;
`ifdef SHIFT_CTRL_DUTY_EN
            pend_duty   <= '0;
`endif
        end else if (state == IDLE || wrap) begin
            pending <= 1'b0;
        end else if (update) begin
            pending     <= 1'b1;
            pend_period <= period_in;
            pend_shift  <= shift;
`ifdef SHIFT_CTRL_DUTY_EN
            pend_duty   <= duty;
`endif
        end
    end

    // Shadow registers used by the waveform datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_period <= '0;
            shadow_shift  <= '0;
`ifdef SHIFT_CTRL_DUTY_EN
            shadow_duty   <= '0;
`endif
        end else if (load_input) begin
            shadow_period <= period_in;
            shadow_shift  <= shift;
`ifdef SHIFT_CTRL_DUTY_EN
            shadow_duty   <= duty;
`endif
        end else if (load_pend) begin
            shadow_period <= pend_period;
            shadow_shift  <= pend_shift;
`ifdef SHIFT_CTRL_DUTY_EN
            shadow_duty   <= pend_duty;
`endif
        end
    end

    assign cnt_x = {1'b0, cnt};
    assign per_x = {1'b0, shadow_period};
`ifdef SHIFT_CTRL_DUTY_EN
    assign thr_x = {1'b0, shadow_duty};
`else
    assign thr_x = per_x >> 1;
`endif

    // Per-channel phase with one guard bit so cnt + period never overflows.
    // A zero shadow period only exists straight out of reset and is not an error.
    always_comb begin
        ch_next = '0;
        err     = '0;
        sh_x    = '0;
        phase   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sh_x       = {1'b0, shadow_shift[k*CNT_W +: CNT_W]};
            phase      = (cnt_x >= sh_x) ? (cnt_x - sh_x) : (cnt_x + per_x - sh_x);
            err[k]     = (shadow_period != '0) && (sh_x >= per_x);
            ch_next[k] = (state != IDLE) && !err[k] && (phase < thr_x);
        end
    end

    // Registered outputs, all one cycle behind the counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_out <= '0;
            sync   <= 1'b0;
            done   <= 1'b0;
        end else begin
            ch_out <= ch_next;
            sync   <= (state != IDLE) && (cnt == '0);
            done   <= finish;
        end
    end

endmodule

// File: tb/tb_ultrasonic_phase_gen.sv
// tb_ultrasonic_phase_gen
// Self-checking bench for ultrasonic_phase_gen: directed scenarios plus a
// randomized run compared cycle by cycle against an integer reference model.
module tb_ultrasonic_phase_gen;

    localparam int NUM_CH     = 4;
    localparam int CNT_W      = 16;
    localparam int MIN_PERIOD = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        update;
    logic [15:0] period;
    logic [63:0] shift;
    logic [15:0] burst_len;
    logic [15:0] duty;
    logic [3:0]  ch_out;
    logic        sync;
    logic        busy;
    logic        done;
    logic [3:0]  shift_err;

    always #5 clock = ~clock;

    ultrasonic_phase_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .update(update),
        .period(period), .shift(shift), .burst_len(burst_len),
`ifdef SHIFT_CTRL_DUTY_EN
        .duty(duty),
`endif
        .ch_out(ch_out), .sync(sync), .busy(busy), .done(done),
        .shift_err(shift_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state 0 idle, 1 run, 2 stop; plain integers throughout.
    int m_state, m_cnt, m_pc, m_per, m_du, m_pend, p_per, p_du;
    int m_sh[NUM_CH];
    int p_sh[NUM_CH];
    logic [3:0] e_ch;
    logic       e_sync, e_done;
    int  out_cnt;
    bit  out_run;

    int cyc = 0, last_sync = 0, sync_seen = 0, done_seen = 0;
    int gaps[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack_sh(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic int clampp(input int p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_pc = 0; m_per = 0; m_du = 0; m_pend = 0;
        p_per = 0; p_du = 0;
        for (int k = 0; k < NUM_CH; k++) begin m_sh[k] = 0; p_sh[k] = 0; end
        e_ch = '0; e_sync = 0; e_done = 0;
    endtask

    task automatic load_inputs();
        m_per = clampp(int'(period));
        m_du  = int'(duty);
        for (int k = 0; k < NUM_CH; k++) m_sh[k] = int'(shift[k*16 +: 16]);
    endtask

    // One clock edge of the model, using the inputs the DUT just sampled.
    task automatic model_step();
        int  thr, ph, bl;
        bit  wr, last;
`ifdef SHIFT_CTRL_DUTY_EN
        thr = m_du;
`else
        thr = m_per / 2;
`endif
        out_cnt = m_cnt;
        out_run = (m_state != 0);
        for (int k = 0; k < NUM_CH; k++) begin
            e_ch[k] = 1'b0;
            if (m_state != 0 && m_sh[k] < m_per) begin
                ph = (m_cnt - m_sh[k] + m_per) % m_per;
                e_ch[k] = (ph < thr);
            end
        end
        e_sync = (m_state != 0) && (m_cnt == 0);
        e_done = 1'b0;
        bl = int'(burst_len);
        if (m_state == 0) begin
            if (enable || update) load_inputs();
            if (enable) begin m_state = 1; m_cnt = 0; m_pc = 0; end
            m_pend = 0;
        end else begin
            wr   = (m_cnt == m_per - 1);
            last = (bl != 0) && (m_pc == bl - 1);
            if (wr) begin
                if (update) load_inputs();
                else if (m_pend != 0) begin
                    m_per = p_per; m_du = p_du;
                    for (int k = 0; k < NUM_CH; k++) m_sh[k] = p_sh[k];
                end
                m_pend = 0; m_cnt = 0; m_pc++;
            end else begin
                if (update) begin
                    p_per = clampp(int'(period)); p_du = int'(duty);
                    for (int k = 0; k < NUM_CH; k++) p_sh[k] = int'(shift[k*16 +: 16]);
                    m_pend = 1;
                end
                m_cnt++;
            end
            if (wr && last) begin m_state = 0; e_done = 1'b1; end
            else if (m_state == 1 && !enable) m_state = 2;
            else if (m_state == 2 && enable) m_state = 1;
            else if (m_state == 2 && wr) m_state = 0;
        end
    endtask

    function automatic logic [3:0] exp_err();
        logic [3:0] e;
        for (int k = 0; k < NUM_CH; k++) e[k] = (m_per != 0) && (m_sh[k] >= m_per);
        return e;
    endfunction

    // Drive one cycle of inputs, step the model on the edge, compare at negedge.
    task automatic applyStimulus(input bit en, input bit upd, input int per,
                                 input logic [63:0] sh, input int bl, input int du);
        enable = en; update = upd; period = 16'(per); shift = sh;
        burst_len = 16'(bl); duty = 16'(du);
        @(posedge clock);
        model_step();
        @(negedge clock);
        cyc++;
        checkOutput("ch_out", ch_out, e_ch);
        checkOutput("sync", sync, e_sync);
        checkOutput("done", done, e_done);
        checkOutput("busy", busy, m_state != 0);
        checkOutput("shift_err", shift_err, exp_err());
        if (sync === 1'b1) begin
            gaps.push_back(cyc - last_sync);
            last_sync = cyc;
            sync_seen++;
        end
        if (done === 1'b1) done_seen++;
    endtask

    task automatic wind_down(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 10, pack_sh(0, 5, 9, 2), 0, 5);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] sh32, sh35;
        int n0, s0, d0, p, bl, du, en;
        logic [63:0] sh;
        sh32 = pack_sh(0, 5, 9, 2);
        sh35 = pack_sh(0, 12, 9, 2);

        // Reset state.
        reset = 1'b1; enable = 0; update = 0; period = 0; shift = '0;
        burst_len = 0; duty = 0;
        model_reset();
        repeat (2) @(negedge clock);
        checkOutput("rst_ch_out", ch_out, 0);
        checkOutput("rst_sync", sync, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_shift_err", shift_err, 0);
        reset = 1'b0;
        wind_down(5);

        // Basic four-channel phase pattern.
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1, 0, 10, sh32, 0, 5);
            if (out_run) begin
                checkOutput("r32_ch0", ch_out[0], out_cnt < 5);
                checkOutput("r32_ch1", ch_out[1], out_cnt >= 5);
                checkOutput("r32_ch2", ch_out[2], (out_cnt == 9) || (out_cnt <= 3));
                checkOutput("r32_ch3", ch_out[3], (out_cnt >= 2) && (out_cnt <= 6));
            end
        end
        checkOutput("r32_gap", gaps[$], 10);

        // Period change mid-period takes effect at the next wrap.
        for (int i = 0; i < 20 && m_cnt != 3; i++) applyStimulus(1, 0, 10, sh32, 0, 5);
        applyStimulus(1, 1, 20, sh32, 0, 5);
        n0 = gaps.size();
        for (int i = 0; i < 60 && gaps.size() < n0 + 2; i++) applyStimulus(1, 0, 20, sh32, 0, 5);
        checkOutput("r33_syncs", gaps.size() - n0, 2);
        if (gaps.size() >= n0 + 2) begin
            checkOutput("r33_gap_old", gaps[n0], 10);
            checkOutput("r33_gap_new", gaps[n0+1], 20);
        end
        wind_down(30);

        // Finite burst.
        s0 = sync_seen; d0 = done_seen;
        for (int i = 0; i < 60 && done_seen == d0; i++) applyStimulus(1, 0, 8, pack_sh(0, 1, 2, 3), 3, 4);
        wind_down(5);
        checkOutput("r34_syncs", sync_seen - s0, 3);
        checkOutput("r34_dones", done_seen - d0, 1);
        checkOutput("r34_busy", busy, 0);

        // Out-of-range shift on channel 1.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 0, 10, sh35, 0, 5);
            if (out_run) begin
                checkOutput("r35_ch1", ch_out[1], 0);
                checkOutput("r35_ch0", ch_out[0], out_cnt < 5);
            end
        end
        checkOutput("r35_err", shift_err, 4'b0010);
        wind_down(30);

        // Asynchronous reset mid-period, then restart with enable held.
        for (int i = 0; i < 30 && !(m_state != 0 && m_cnt == 6); i++) applyStimulus(1, 0, 10, sh32, 0, 5);
        #2 reset = 1'b1;
        #1;
        checkOutput("r36_ch_out", ch_out, 0);
        checkOutput("r36_sync", sync, 0);
        checkOutput("r36_busy", busy, 0);
        checkOutput("r36_shift_err", shift_err, 0);
        model_reset();
        #1 reset = 1'b0;
        applyStimulus(1, 0, 10, sh32, 0, 5);
        checkOutput("r36_restart_quiet", sync, 0);
        applyStimulus(1, 0, 10, sh32, 0, 5);
        checkOutput("r36_restart_sync", sync, 1);
        checkOutput("r36_restart_ch0", ch_out[0], 1);
        wind_down(30);

`ifdef SHIFT_CTRL_DUTY_EN
        // Programmable duty.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 0, 10, sh32, 0, 3);
            if (out_run) checkOutput("r37_duty3", ch_out[0], out_cnt < 3);
        end
        wind_down(30);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 0, 10, sh32, 0, 15);
            if (out_run) checkOutput("r37_duty15", ch_out[0], 1);
        end
        wind_down(30);
`endif

        // Randomized run against the model.
        p = 10; sh = sh32; bl = 0; du = 5; en = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                p  = $urandom_range(1, 30);
                sh = pack_sh($urandom_range(0, p + 2), $urandom_range(0, p + 2),
                             $urandom_range(0, p + 2), $urandom_range(0, p + 2));
                bl = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
                du = $urandom_range(0, p + 2);
            end
            if ($urandom_range(0, 24) == 0) en = 1 - en;
            applyStimulus(en[0], $urandom_range(0, 11) == 0, p, sh, bl, du);
        end
        wind_down(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ultrasonic_phase_gen.md
ULTRASONIC_PHASE_GEN -- requirements
Module: ultrasonic_phase_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of transducer channels.
REQ-002 SHALL have parameter CNT_W, default 16, width of the period, shift and duty values.
REQ-003 SHALL have parameter MIN_PERIOD, default 4, smallest period applied; smaller programmed values are clamped up to it.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  level; run request, taken from the AXI control register.
REQ-007 SHALL have port update  input  1  one-cycle strobe; requests a load of period/shift/duty into the shadow registers.
REQ-008 SHALL have port period  input  CNT_W  carrier period in clocks (2500 = 40 kHz at 100 MHz).
REQ-009 SHALL have port shift  input  NUM_CH*CNT_W  per-channel delay in clocks; channel k at bits [k*CNT_W +: CNT_W].
REQ-010 SHALL have port burst_len  input  CNT_W  periods per burst; 0 = continuous.
REQ-011 SHALL have port ch_out  output  NUM_CH  transducer drive square waves.
REQ-012 SHALL have port sync  output  1  one-cycle pulse at the start of each period.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a finite burst completes.
REQ-015 SHALL have port shift_err  output  NUM_CH  bit k set while the shadow shift of channel k is >= the shadow period.

Function
REQ-016 SHALL implement the states IDLE, RUN and STOP.
REQ-017 IDLE -> RUN SHALL occur on the first edge with enable=1; on that edge shadow registers load from the inputs, the counter loads 0 and the period count loads 0.
REQ-018 In RUN/STOP the counter SHALL increment each cycle and wrap from shadow_period-1 to 0; each wrap increments the period count.
REQ-019 In RUN, enable=0 SHALL move the state to STOP; STOP returns to RUN if enable=1 before the next wrap, otherwise goes to IDLE on the next wrap.
REQ-020 When burst_len != 0, a wrap with period count = burst_len-1 SHALL go to IDLE and pulse done on the following cycle.
REQ-021 An update strobe SHALL set a pending flag; the shadow registers load at the next wrap, or immediately if in IDLE.
REQ-022 Update coincident with a wrap SHALL load on that wrap; a second update before the load SHALL replace the first, and only the latest input values load.
REQ-023 Per channel, phase = cnt - shift if cnt >= shift, else cnt + period - shift, using shadow values and CNT_W+1-bit intermediates with no overflow.
REQ-024 ch_out[k] SHALL be registered high iff phase < (period >> 1), giving 1 cycle of latency from the counter.
REQ-025 A channel with shift >= period SHALL drive ch_out[k]=0 and set shift_err[k].
REQ-026 sync SHALL be registered high for one cycle when cnt = 0 in RUN/STOP, aligned with ch_out.
REQ-027 In IDLE, ch_out and sync SHALL be 0.

Reset
REQ-028 Reset SHALL act asynchronously, including mid-burst: state IDLE; counter, period count, pending flag, shadows, ch_out, sync, busy, done and shift_err all 0.
REQ-029 After reset deasserts, no output SHALL change until enable is sampled high.

Configuration
REQ-030 With SHIFT_CTRL_DUTY_EN defined, the block SHALL add the port duty (input, CNT_W), shadowed like period, and ch_out[k] is high iff phase < duty; duty >= period gives a constant high.
REQ-031 Without SHIFT_CTRL_DUTY_EN, the duty port SHALL be absent and the fixed 50 % rule of REQ-024 SHALL apply.

Verification
REQ-032 period=10, shift={0,5,9,2}, burst_len=0, enable=1 -> ch0 high for cnt 0-4, ch1 high for cnt 5-9, ch2 high for cnt 9 and 0-3, ch3 high for cnt 2-6; sync every 10 cycles.
REQ-033 Running at period=10, update with period=20 at cnt=3 -> the current period completes at 10 clocks, and the next sync arrives 20 clocks after that.
REQ-034 burst_len=3, period=8 -> exactly 3 sync pulses, done 1 cycle after the last wrap, busy low afterwards.
REQ-035 period=10, shift1=12 -> shift_err=4'b0010, ch1 stays 0, other channels unaffected.
REQ-036 Reset asserted mid-period at cnt=6 -> all outputs 0 asynchronously; with enable held high, the restart after release begins at cnt 0.
REQ-037 SHIFT_CTRL_DUTY_EN, period=10, duty=3, shift0=0 -> ch0 high for cnt 0-2; duty=15 -> ch0 constantly high.
